// File: rtl/x_mod_seq_reducer_if.sv
// Valid/ready bundle between an operand producer, the reducer and a residue consumer.
// The master side drives X and consumes R.
interface x_mod_seq_reducer_if #(
    parameter int IN_W  = 200,
    parameter int MOD_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  X;
    logic             out_valid;
    logic             out_ready;
    logic [MOD_W-1:0] R;
    logic             busy;

    modport master (
        output in_valid, X, out_ready,
        input  in_ready, out_valid, R, busy
    );

    modport slave (
        input  in_valid, X, out_ready,
        output in_ready, out_valid, R, busy
    );
endinterface

// File: rtl/x_mod_seq_reducer.sv
// Sequential X mod MOD reducer: Horner folding of CHUNK_W-bit chunks, MSB first,
// with a restoring subtract chain per step.
module x_mod_seq_reducer #(
    parameter int IN_W    = 200,
    parameter int MOD     = 241,
    parameter int MOD_W   = 8,
    parameter int CHUNK_W = 8
) (
    input logic clk,
    input logic rst_n,
    x_mod_seq_reducer_if.slave bus
);
    localparam int NCHUNK = (IN_W + CHUNK_W - 1) / CHUNK_W;
    localparam int SH_W   = NCHUNK * CHUNK_W;
    localparam int T_W    = MOD_W + CHUNK_W;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [T_W-1:0]   MOD_T   = T_W'(MOD);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [SH_W-1:0]  sh;
    logic [MOD_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [T_W-1:0]   t;
    logic [T_W-1:0]   r;
    logic [MOD_W-1:0] acc_nxt;

    assign bus.in_ready = (state == IDLE) | ((state == DONE) & bus.out_ready);

    // acc < MOD keeps t below MOD<<CHUNK_W, so the chain always lands below MOD
    always_comb begin
        t = {acc, sh[SH_W-1 -: CHUNK_W]};
        r = t;
        for (int i = CHUNK_W; i >= 0; i--) begin
            if (r >= (MOD_T << i)) begin
                r = r - (MOD_T << i);
            end
        end
        acc_nxt = MOD_W'(r);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sh            <= '0;
            acc           <= '0;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.R         <= '0;
            bus.busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sh       <= SH_W'(bus.X);
                        acc      <= '0;
                        cnt      <= CNT_TOP;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    sh  <= sh << CHUNK_W;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        bus.R         <= acc_nxt;
                        bus.out_valid <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (bus.in_valid) begin
                            sh       <= SH_W'(bus.X);
                            acc      <= '0;
                            cnt      <= CNT_TOP;
                            bus.busy <= 1'b1;
                            state    <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
